// File: rtl/latch_array_drain.sv
// rtl/latch_array_drain.sv - write-back engine draining the mac_16 latch array into the output SRAM
//
// Purpose: on start, snapshots the full latch array and base address, pulses
// clr_acc so the MAC array can begin the next tile, then writes the snapshot
// row by row (base+r) into the output SRAM using a we/wready handshake, and
// finishes with a one-cycle done pulse.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, base_addr  drain request and SRAM address of row 0
//   latch_array_in    ROWS*ROW_W latch array, row r = [r*ROW_W +: ROW_W]
//   sram_wready       SRAM accepts the presented write this cycle
//   sram_we/addr/wdata  registered SRAM write request
//   busy, done, clr_acc  registered status pulses
module latch_array_drain #(
    parameter int ROWS   = 16,
    parameter int ROW_W  = 384,
    parameter int ADDR_W = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ROWS*ROW_W-1:0]   latch_array_in,
    input  logic                    sram_wready,
    output logic                    sram_we,
    output logic [ADDR_W-1:0]       sram_addr,
    output logic [ROW_W-1:0]        sram_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    clr_acc
);

    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        row, row_nxt, row_inc;
    logic [ROWS*ROW_W-1:0]   snap, snap_nxt;
    logic [ADDR_W-1:0]       base, base_nxt;
    logic                    we_nxt, busy_nxt, done_nxt, clr_nxt;
    logic [ADDR_W-1:0]       addr_nxt;
    logic [ROW_W-1:0]        wdata_nxt;
    logic                    xfer;

    assign xfer    = sram_we && sram_wready;
    assign row_inc = row + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        snap_nxt  = snap;
        base_nxt  = base;
        we_nxt    = sram_we;
        addr_nxt  = sram_addr;
        wdata_nxt = sram_wdata;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        clr_nxt   = 1'b0;

        case (state)
            IDLE: begin
                // The cycle showing the done pulse still belongs to the
                // completion phase, so a start seen there is not accepted.
                if (start && !done) begin
                    snap_nxt  = latch_array_in;
                    base_nxt  = base_addr;
                    row_nxt   = '0;
                    state_nxt = WRITE;
                    busy_nxt  = 1'b1;
                    clr_nxt   = 1'b1;
                    we_nxt    = 1'b1;
                    addr_nxt  = base_addr;
                    // Row 0 of the snapshot equals row 0 of the input at capture.
                    wdata_nxt = latch_array_in[ROW_W-1:0];
                end
            end
            WRITE: begin
                // While stalled nothing changes, so address and data hold.
                if (xfer) begin
                    if (row == LAST_ROW) begin
                        state_nxt = DONE;
                        we_nxt    = 1'b0;
                    end else begin
                        row_nxt   = row_inc;
                        // Wraps modulo 2^ADDR_W by construction.
                        addr_nxt  = base + ADDR_W'(row_inc);
                        wdata_nxt = snap[row_inc*ROW_W +: ROW_W];
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            snap       <= '0;
            base       <= '0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            clr_acc    <= 1'b0;
        end else begin
            state      <= state_nxt;
            row        <= row_nxt;
            snap       <= snap_nxt;
            base       <= base_nxt;
            sram_we    <= we_nxt;
            sram_addr  <= addr_nxt;
            sram_wdata <= wdata_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            clr_acc    <= clr_nxt;
        end
    end

endmodule

// File: tb/tb_latch_array_drain.sv
// tb/tb_latch_array_drain.sv - self-checking bench for latch_array_drain
module tb_latch_array_drain;
    localparam int ROWS   = 16;
    localparam int ROW_W  = 384;
    localparam int ADDR_W = 11;
    localparam int TW     = ROWS * ROW_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [TW-1:0]     latch_array_in;
    logic              sram_wready;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [ROW_W-1:0]  sram_wdata;
    logic              busy;
    logic              done;
    logic              clr_acc;

    int checks   = 0;
    int failures = 0;

    // Observations collected by the drain driver, judged by each test.
    int               ob_addr[$];
    logic [ROW_W-1:0] ob_data[$];
    int ob_last_xfer, ob_done_cycle, ob_done_cnt, ob_busy_cnt, ob_clr_cnt;
    int ob_clr_cycle, ob_we_first, ob_stall_bad, ob_row5_cycles;
    int ob_rst_cycle, ob_after_rst;

    always #5 clk = ~clk;

    latch_array_drain #(.ROWS(ROWS), .ROW_W(ROW_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .latch_array_in(latch_array_in), .sram_wready(sram_wready),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .busy(busy), .done(done), .clr_acc(clr_acc)
    );

    // Reference: row r goes to (base + r) mod 2^ADDR_W.
    function automatic int exp_addr(input int base, input int r);
        return (base + r) % (1 << ADDR_W);
    endfunction

    function automatic logic [TW-1:0] rand_tile();
        logic [TW-1:0] t;
        for (int i = 0; i < TW / 32; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    // mode: 0 wready=1, 1 wready low on odd cycles, 2 ten stalls on row 5, 3 random
    // opt : 0 none, 1 change input after start, 2 second start at row 3, 3 reset at row 7
    task automatic drain(input int base, input logic [TW-1:0] tile, input int mode, input int opt);
        logic             prev_stall;
        logic [ADDR_W-1:0] pa;
        logic [ROW_W-1:0]  pd;
        int stall5, post;
        bit restarted;
        ob_addr.delete(); ob_data.delete();
        ob_last_xfer = -1; ob_done_cycle = -1; ob_done_cnt = 0; ob_busy_cnt = 0;
        ob_clr_cnt = 0; ob_clr_cycle = -1; ob_we_first = -1; ob_stall_bad = 0;
        ob_row5_cycles = 0; ob_rst_cycle = -1; ob_after_rst = -1;
        prev_stall = 1'b0; pa = '0; pd = '0; stall5 = 0; post = -1; restarted = 1'b0;
        base_addr = ADDR_W'(base);
        latch_array_in = tile;
        sram_wready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k < 300; k++) begin
            start = 1'b0;
            rst   = 1'b0;
            if (opt == 1 && k == 1) latch_array_in = '1;
            if (sram_we && ob_we_first < 0) ob_we_first = k;
            if (clr_acc) begin ob_clr_cnt++; ob_clr_cycle = k; end
            if (busy) ob_busy_cnt++;
            if (done) begin ob_done_cnt++; if (ob_done_cycle < 0) ob_done_cycle = k; end
            if (prev_stall && (!sram_we || sram_addr !== pa || sram_wdata !== pd)) ob_stall_bad++;
            if (ob_rst_cycle >= 0 && k == ob_rst_cycle + 1)
                ob_after_rst = int'(sram_we) + int'(busy) + int'(done) + int'(clr_acc)
                             + int'(|sram_addr) + int'(|sram_wdata);
            case (mode)
                0: sram_wready = 1'b1;
                1: sram_wready = (k % 2 == 0);
                2: sram_wready = !(sram_we && sram_addr == ADDR_W'(base + 5) && stall5 < 10);
                default: sram_wready = ($urandom_range(0, 3) != 0);
            endcase
            if (mode == 2 && sram_we && !sram_wready) stall5++;
            if (sram_we && sram_addr == ADDR_W'(base + 5)) ob_row5_cycles++;
            if (opt == 2 && !restarted && sram_we && sram_addr == ADDR_W'(base + 3)) begin
                start = 1'b1; restarted = 1'b1;
            end
            if (opt == 3 && ob_rst_cycle < 0 && sram_we && sram_addr == ADDR_W'(base + 7)) begin
                rst = 1'b1; ob_rst_cycle = k; sram_wready = 1'b0;
            end
            if (sram_we && sram_wready && !rst) begin
                ob_addr.push_back(int'(sram_addr));
                ob_data.push_back(sram_wdata);
                ob_last_xfer = k;
            end
            prev_stall = sram_we && !sram_wready && !rst;
            pa = sram_addr; pd = sram_wdata;
            if (post < 0 && (ob_done_cycle >= 0 || (ob_rst_cycle >= 0 && k >= ob_rst_cycle + 20))) post = k;
            if (post >= 0 && k >= post + 3) break;
            @(posedge clk); #1;
        end
        start = 1'b0; rst = 1'b0; sram_wready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; sram_wready = 1'b1;
        base_addr = ADDR_W'($urandom); latch_array_in = rand_tile();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({sram_we, busy, done, clr_acc, |sram_addr, |sram_wdata} !== 6'b0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: we=%b busy=%b done=%b clr=%b addr=%0d, required all 0",
                         i, sram_we, busy, done, clr_acc, sram_addr);
            end
        end
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({sram_we, busy, clr_acc} !== 3'b0) begin
                failures++;
                $display("FAIL reset_no_capture: we=%b busy=%b clr=%b, required 0", sram_we, busy, clr_acc);
            end
        end
    endtask

    task automatic test_basic();
        logic [TW-1:0] t;
        int bad;
        for (int r = 0; r < ROWS; r++) t[r*ROW_W +: ROW_W] = {(ROW_W/8){8'(r)}};
        drain(0, t, 0, 0);
        checks++; bad = 0;
        for (int r = 0; r < ROWS; r++)
            if (r >= ob_addr.size() || ob_addr[r] != exp_addr(0, r) || ob_data[r] !== t[r*ROW_W +: ROW_W]) bad++;
        if (bad != 0 || ob_addr.size() != ROWS) begin
            failures++;
            $display("FAIL basic_rows: %0d wrong of %0d writes, required 0 wrong of %0d", bad, ob_addr.size(), ROWS);
        end
        checks++;
        if (ob_we_first != 1 || ob_clr_cycle != 1 || ob_clr_cnt != 1) begin
            failures++;
            $display("FAIL basic_first: we_first=%0d clr_cycle=%0d clr_cnt=%0d, required 1 1 1",
                     ob_we_first, ob_clr_cycle, ob_clr_cnt);
        end
        checks++;
        if (ob_done_cycle != 18 || ob_done_cnt != 1) begin
            failures++;
            $display("FAIL basic_done: cycle=%0d count=%0d, required 18 1", ob_done_cycle, ob_done_cnt);
        end
        checks++;
        if (ob_busy_cnt != 17) begin
            failures++;
            $display("FAIL basic_busy: %0d cycles, required 17", ob_busy_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [TW-1:0] t;
        int base, bad;
        t = rand_tile(); base = $urandom_range(0, 2047);
        drain(base, t, 1, 0);
        checks++; bad = 0;
        for (int r = 0; r < ROWS; r++)
            if (r >= ob_addr.size() || ob_addr[r] != exp_addr(base, r) || ob_data[r] !== t[r*ROW_W +: ROW_W]) bad++;
        if (bad != 0 || ob_addr.size() != ROWS) begin
            failures++;
            $display("FAIL alt_rows: %0d wrong of %0d writes, required 0 wrong of %0d", bad, ob_addr.size(), ROWS);
        end
        checks++;
        if (ob_done_cycle != 34 || ob_stall_bad != 0) begin
            failures++;
            $display("FAIL alt_done_stall: done=%0d unstable=%0d, required 34 0", ob_done_cycle, ob_stall_bad);
        end
        t = rand_tile(); base = $urandom_range(0, 2047);
        drain(base, t, 2, 0);
        checks++;
        if (ob_row5_cycles != 11 || ob_stall_bad != 0) begin
            failures++;
            $display("FAIL row5_hold: cycles=%0d unstable=%0d, required 11 0", ob_row5_cycles, ob_stall_bad);
        end
        checks++; bad = 0;
        for (int r = 0; r < ROWS; r++)
            if (r >= ob_addr.size() || ob_addr[r] != exp_addr(base, r) || ob_data[r] !== t[r*ROW_W +: ROW_W]) bad++;
        if (bad != 0 || ob_addr.size() != ROWS || ob_done_cycle != 28) begin
            failures++;
            $display("FAIL row5_rows: %0d wrong of %0d, done=%0d, required 0 of %0d, done 28",
                     bad, ob_addr.size(), ob_done_cycle, ROWS);
        end
    endtask

    task automatic test_isolation();
        logic [TW-1:0] t;
        int base, bad;
        t = rand_tile(); base = $urandom_range(0, 2047);
        drain(base, t, 0, 1);
        checks++; bad = 0;
        for (int r = 0; r < ROWS; r++)
            if (r >= ob_data.size() || ob_data[r] !== t[r*ROW_W +: ROW_W]) bad++;
        if (bad != 0 || ob_data.size() != ROWS) begin
            failures++;
            $display("FAIL isolation_rows: %0d wrong of %0d writes, required 0 wrong of %0d", bad, ob_data.size(), ROWS);
        end
    endtask

    task automatic test_wrap_ignore();
        logic [TW-1:0] t;
        int bad;
        t = rand_tile();
        drain(2040, t, 0, 2);
        checks++; bad = 0;
        for (int r = 0; r < ROWS; r++)
            if (r >= ob_addr.size() || ob_addr[r] != exp_addr(2040, r) || ob_data[r] !== t[r*ROW_W +: ROW_W]) bad++;
        if (bad != 0 || ob_addr.size() != ROWS) begin
            failures++;
            $display("FAIL wrap_rows: %0d wrong of %0d writes, required 0 wrong of %0d", bad, ob_addr.size(), ROWS);
        end
        checks++;
        if (ob_clr_cnt != 1 || ob_done_cycle != 18 || ob_done_cnt != 1) begin
            failures++;
            $display("FAIL ignore_start: clr=%0d done_cycle=%0d done_cnt=%0d, required 1 18 1",
                     ob_clr_cnt, ob_done_cycle, ob_done_cnt);
        end
    endtask

    task automatic test_mid_reset();
        logic [TW-1:0] t;
        int base, bad;
        t = rand_tile(); base = $urandom_range(0, 2047);
        drain(base, t, 0, 3);
        checks++;
        if (ob_after_rst != 0 || ob_done_cnt != 0 || ob_addr.size() != 7) begin
            failures++;
            $display("FAIL mid_reset: active_outputs=%0d done_cnt=%0d writes=%0d, required 0 0 7",
                     ob_after_rst, ob_done_cnt, ob_addr.size());
        end
        for (int it = 0; it < 4; it++) begin
            t = rand_tile(); base = $urandom_range(0, 2047);
            drain(base, t, 3, 0);
            checks++; bad = 0;
            for (int r = 0; r < ROWS; r++)
                if (r >= ob_addr.size() || ob_addr[r] != exp_addr(base, r) || ob_data[r] !== t[r*ROW_W +: ROW_W]) bad++;
            if (bad != 0 || ob_addr.size() != ROWS || ob_stall_bad != 0) begin
                failures++;
                $display("FAIL random_rows %0d: %0d wrong of %0d, unstable=%0d, required 0 of %0d, 0",
                         it, bad, ob_addr.size(), ob_stall_bad, ROWS);
            end
            checks++;
            if (ob_done_cycle != ob_last_xfer + 2 || ob_done_cnt != 1 || ob_busy_cnt != ob_last_xfer + 1
                || ob_clr_cnt != 1) begin
                failures++;
                $display("FAIL random_timing %0d: done=%0d cnt=%0d busy=%0d clr=%0d, required done=%0d cnt=1 busy=%0d clr=1",
                         it, ob_done_cycle, ob_done_cnt, ob_busy_cnt, ob_clr_cnt, ob_last_xfer + 2, ob_last_xfer + 1);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sram_wready = 1'b1; base_addr = '0; latch_array_in = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_isolation();
        test_wrap_ignore();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/latch_array_drain.md
Name: latch_array_drain

Overview:
- Write-back engine on the output side of mac_16.
- On a start pulse, snapshots the 6144-bit latch_array_out (16 rows × 384 bits) and writes it row by row into the single-bank output SRAM.
- Uses a write/ready handshake, then pulses done.
- Releases the MAC array for the next tile by pulsing clr_acc immediately after the snapshot, so accumulation of the next tile overlaps the drain.

Parameters:
- ROWS, 16, number of latch-array rows drained per tile.
- ROW_W, 384, bits per row (one output SRAM word).
- ADDR_W, 11, output SRAM address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to drain the current latch array; sampled on a rising edge.
- base_addr  input  ADDR_W  SRAM address of row 0; sampled together with start.
- latch_array_in  input  ROWS*ROW_W  latch_array_out from mac_16; row r = bits [r*ROW_W +: ROW_W].
- sram_wready  input  1  SRAM accepts a write this cycle.
- sram_we  output  1  write request valid.
- sram_addr  output  ADDR_W  write address.
- sram_wdata  output  ROW_W  write data.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse after the last row is accepted.
- clr_acc  output  1  one-cycle pulse telling mac_16 the accumulators may be cleared.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; sram_we=0, sram_addr=0, sram_wdata=0, busy=0, done=0, clr_acc=0; row counter=0; snapshot register cleared.
- All outputs are registered.
- States: IDLE, WRITE, DONE.
- IDLE:
  - If start=1 at an edge: capture latch_array_in into the snapshot and base_addr into the address base; row=0; go to WRITE.
  - In the next cycle: busy=1, clr_acc=1 (one cycle only), sram_we=1, sram_addr=base_addr, sram_wdata=snapshot row 0.
  - Start-to-first-write latency: 1 cycle.
- WRITE:
  - A row transfers at an edge where sram_we=1 and sram_wready=1.
  - On transfer of row r<ROWS-1: row=r+1; next cycle sram_addr=base+r+1 and sram_wdata=snapshot row r+1; sram_we stays 1.
  - If sram_wready=0: hold sram_we, sram_addr and sram_wdata stable until accepted (no data or address change while stalled).
  - On transfer of row ROWS-1: go to DONE; next cycle sram_we=0.
- DONE:
  - done=1 and busy=0 for exactly one cycle; sram_addr and sram_wdata hold their last values; then IDLE.
  - A start in the DONE cycle is ignored.
- Minimum tile time with wready tied high: 1 + ROWS + 1 = 18 cycles from start to done.
- Address arithmetic is modulo 2^ADDR_W; base+r wraps past 2^ADDR_W-1 to 0 with no error.
- start while busy (WRITE) is ignored: no re-capture, no extra clr_acc, counter unaffected.
- latch_array_in changing after capture has no effect on the written data.
- rst asserted mid-drain takes priority over every other event: return to IDLE with reset values next cycle; no done pulse; remaining rows are dropped.
- start and rst high together: reset wins, nothing captured.
- Bits are not reordered: sram_wdata is the exact ROW_W slice, MSB to MSB.

Test Plan:
- Reset: hold rst for 3 cycles with start=1 -> all outputs 0 throughout, no capture, no clr_acc.
- Basic drain: base_addr=0, row r filled with the 8-bit value r repeated; wready=1; pulse start.
  - Expected: clr_acc and sram_we high 1 cycle after start; addresses 0..15 on 16 consecutive cycles with matching data; done 18 cycles after start; busy high for 17 cycles.
- Backpressure: drive wready=0 on every other cycle.
  - Expected: each row held stable while stalled; 16 writes in order; done at start+1+32+1.
  - Also: wready=0 for 10 cycles on row 5 -> address 5 held for 10 cycles.
- Snapshot isolation: change latch_array_in to all-ones 1 cycle after start -> SRAM receives the pre-start values.
- Wrap and ignore: base_addr=2040, and pulse start again at row 3.
  - Expected: addresses 2040..2047 then 0..7; the second start causes no extra clr_acc and no restart.
- Mid-drain reset: rst at row 7 -> sram_we=0 next cycle, no done pulse; a subsequent start drains a full new tile correctly.
